// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst responder backed by a byte-writable on-chip RAM; one write and one read in flight.
// Define AXI_MEM_SLAVE_BP_EN to add LFSR-driven backpressure on s_awready/s_wready.
`timescale 1ns/1ps
module axi_mem_slave #(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_ADDR_WIDTH = 64,
  parameter int C_AXI_DATA_WIDTH = 256,
  parameter int MEM_DEPTH_LOG2   = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [C_AXI_ID_WIDTH-1:0]     s_awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]                    s_awlen,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   s_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                          s_wlast,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [C_AXI_ID_WIDTH-1:0]     s_bid,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  input  logic [C_AXI_ID_WIDTH-1:0]     s_arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]                    s_arlen,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [C_AXI_ID_WIDTH-1:0]     s_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic                          s_rvalid,
  input  logic                          s_rready
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [C_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t                  w_state, w_next;
  logic                      awready_q, wready_q;
  logic [MEM_DEPTH_LOG2-1:0] widx;
  logic [7:0]                wcnt;
  logic                      werr;
  logic                      aw_hs, w_hs, b_hs, w_final, wlast_bad;

  r_state_t                  r_state, r_next;
  logic [MEM_DEPTH_LOG2-1:0] ridx, ridx_nxt;
  logic [7:0]                rcnt;
  logic                      ar_hs, r_hs;

`ifdef AXI_MEM_SLAVE_BP_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Only readies are throttled; valids from this side are never withdrawn.
  assign s_awready = awready_q & lfsr[0];
  assign s_wready  = wready_q & lfsr[0];
`else
  assign s_awready = awready_q;
  assign s_wready  = wready_q;
`endif

  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;
  assign b_hs      = s_bvalid & s_bready;
  assign w_final   = w_hs && (wcnt == 8'd0);
  assign wlast_bad = s_wlast ^ (wcnt == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)   w_next = W_DATA;
      W_DATA:  if (w_final) w_next = W_RESP;
      W_RESP:  if (b_hs)    w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Burst length is enforced by count; wlast only feeds the error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bid     <= '0;
      s_bresp   <= 2'b00;
      widx      <= '0;
      wcnt      <= 8'd0;
      werr      <= 1'b0;
    end else begin
      awready_q <= (w_next == W_IDLE);
      wready_q  <= (w_next == W_DATA);
      s_bvalid  <= (w_next == W_RESP);
      if (aw_hs) begin
        s_bid <= s_awid;
        widx  <= s_awaddr[OFFS +: MEM_DEPTH_LOG2];
        wcnt  <= s_awlen;
        werr  <= 1'b0;
      end
      if (w_hs) begin
        widx <= widx + MEM_DEPTH_LOG2'(1);
        wcnt <= wcnt - 8'd1;
        if (wlast_bad) werr <= 1'b1;
      end
      if (w_final) s_bresp <= (werr | wlast_bad) ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_wstrb[b]) mem[widx][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end

  assign ar_hs    = s_arvalid & s_arready;
  assign r_hs     = s_rvalid & s_rready;
  assign ridx_nxt = ridx + MEM_DEPTH_LOG2'(1);
  assign s_rresp  = 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (r_hs && s_rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // rdata is prefetched one word ahead so an accepted beat is replaced on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rlast   <= 1'b0;
      s_rid     <= '0;
      s_rdata   <= '0;
      ridx      <= '0;
      rcnt      <= 8'd0;
    end else begin
      s_arready <= (r_next == R_IDLE);
      s_rvalid  <= (r_next == R_DATA);
      if (ar_hs) begin
        s_rid <= s_arid;
        ridx  <= s_araddr[OFFS +: MEM_DEPTH_LOG2];
        rcnt  <= s_arlen;
      end
      if (r_state == R_FETCH) begin
        s_rdata <= mem[ridx];
        s_rlast <= (rcnt == 8'd0);
      end
      if (r_hs) begin
        if (s_rlast) begin
          s_rlast <= 1'b0;
        end else begin
          s_rdata <= mem[ridx_nxt];
          ridx    <= ridx_nxt;
          rcnt    <= rcnt - 8'd1;
          s_rlast <= (rcnt == 8'd1);
        end
      end
    end
  end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
AXI4 responder (slave) backed by an on-chip byte-writable RAM. It accepts INCR bursts from the DDR-facing AXI master and stands in for the MIG/DDR during bring-up and regression. It also serves as a small on-chip buffer. One outstanding write and one outstanding read; the write and read paths are independent and run concurrently.

Parameters:
C_AXI_ID_WIDTH, 4, ID width
C_AXI_ADDR_WIDTH, 64, address width
C_AXI_DATA_WIDTH, 256, data width (power of two, >=32)
MEM_DEPTH_LOG2, 10, log2 of RAM depth in data-width words

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_awid / s_awaddr / s_awlen  in  ID / ADDR / 8  write address, ID, beats-1
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata / s_wstrb  in  DATA / DATA/8  write data, byte strobes
s_wlast / s_wvalid  in  1 / 1  last beat, write valid
s_wready  out  1  write data ready
s_bid / s_bresp  out  ID / 2  response ID, response code
s_bvalid  out  1  response valid
s_bready  in  1  response ready
s_arid / s_araddr / s_arlen  in  ID / ADDR / 8  read address, ID, beats-1
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rid / s_rdata / s_rresp  out  ID / DATA / 2  read ID, read data, read response
s_rlast / s_rvalid  out  1 / 1  last beat, read valid
s_rready  in  1  read ready

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk. All outputs are 0 during reset, including awready and arready. RAM contents are not reset.
- Word index = (addr >> log2(DATA/8)) mod 2^MEM_DEPTH_LOG2. Each beat increments the index by 1 and wraps to 0. Burst size is always full width; burst type is always INCR. Size, burst, lock, cache and prot are not ported.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, capture id, index and len into wcnt, clear err, then awready<=0, wready<=1, go to W_DATA.
  - W_DATA: on each W handshake, write the bytes of mem[idx] enabled by wstrb, then idx+1 and wcnt-1.
  - Protocol error: set err if wlast=1 on any beat other than the last, or wlast=0 on the last. Termination is by count only; exactly len+1 beats are accepted.
  - On the final beat: wready<=0, bvalid<=1, bid=captured id, bresp=err?2'b10:2'b00. Go to W_RESP.
  - W_RESP: hold bvalid, bid and bresp until bready. On the B handshake: bvalid<=0, awready<=1, go to W_IDLE.
  - W data arriving before AW sees wready=0 and is not consumed.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, capture id, index and len, then arready<=0, go to R_FETCH.
  - R_FETCH: rdata<=mem[idx], rvalid<=1, rlast<=(len==0), go to R_DATA. First beat appears 2 cycles after the AR handshake.
  - R_DATA, on R handshake with beats left: rdata<=mem[idx+1], index advances, rvalid stays 1, rlast<=(remaining==1). This gives full throughput.
  - R_DATA, on R handshake of the rlast beat: rvalid<=0, rlast<=0, arready<=1, go to R_IDLE.
  - While rvalid=1 and rready=0, rid, rdata and rlast are held stable.
  - rresp is always 2'b00.
- Simultaneous write and read of the same word: the read returns the old data (read-first).
- awlen=0 and arlen=0 give single-beat bursts.
- Reset asserted mid-burst: both FSMs return to idle and any burst in flight is abandoned.

Optional Feature:
AXI_MEM_SLAVE_BP_EN:
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5; advances every cycle). When lfsr[0]==0, s_wready and s_awready are forced low. Valid signals are never throttled, so AXI rules hold.
- Undefined: no LFSR; ready signals follow the FSMs exactly as described in Behaviour.

Test Plan:
1. Write awaddr=0, awlen=7, awid=3, wdata=beat index, wstrb all ones, wlast on beat 8 -> bvalid 1 cycle after beat 8 with bid=3, bresp=00.
2. Read araddr=0, arlen=7, arid=5, rready=1 -> rvalid 2 cycles after AR; 8 consecutive beats with data 0..7, rid=5, rlast only on beat 8.
3. Write to word 4 with wstrb=0x0000000F and data all 1s over prior data 0 -> readback 0x...0000FFFFFFFF.
4. awlen=7 with wlast asserted on beat 3 -> still 8 beats accepted, bresp=2'b10; the following burst gives bresp=00.
5. Read arlen=3 with rready toggling 1,0,0,1... -> each beat delivered exactly once; rdata stable while stalled.
6. awaddr=(2^MEM_DEPTH_LOG2-1)*32, awlen=1 -> beat 2 lands at word 0, confirmed by readback.
